// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port among ALU, a buffered load-return FIFO and I/O,
// with starvation boosting and a pending-write mask for decode stall logic.
module regfile_wr_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int Q_DEPTH    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_reg,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_reg,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       mem_ready,
  input  logic                       io_valid,
  input  logic [ADDR_W-1:0]          io_reg,
  input  logic [DATA_W-1:0]          io_data,
  output logic                       io_ready,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic [(2**ADDR_W)-1:0]     pend_mask,
  output logic [$clog2(Q_DEPTH):0]   q_count
);

  localparam int IDX_W = $clog2(Q_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int NREG  = 2**ADDR_W;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_IO   = 2'd3
  } src_e;

  logic [ADDR_W-1:0] q_reg  [Q_DEPTH];
  logic [DATA_W-1:0] q_data [Q_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              q_empty;
  logic              q_full;
  logic              qv;
  logic              push;
  logic              pop;

  logic [SC_W-1:0]   sq;
  logic [SC_W-1:0]   si;
  logic              boost_q;
  logic              boost_i;
  src_e              gnt_src;
  logic [ADDR_W-1:0] gnt_reg;
  logic [DATA_W-1:0] gnt_data;
  logic [NREG-1:0]   pend_c;

  assign wr_idx  = wr_ptr[IDX_W-1:0];
  assign rd_idx  = rd_ptr[IDX_W-1:0];
  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);
  assign q_count = wr_ptr - rd_ptr;
  // Head eligibility comes from registered pointers, so a fresh push waits one cycle.
  assign qv      = !q_empty;

  // Handshake: a source transfers on valid && ready in the same cycle; while valid && !ready
  // the requester holds reg/data stable. ALU/I/O ready is the grant; mem ready is !full only.
  assign mem_ready = !q_full;
  assign push      = mem_valid && !q_full;
  assign pop       = (gnt_src == SRC_FIFO);

  assign boost_q = qv && (sq == SC_MAX);
  assign boost_i = io_valid && (si == SC_MAX);

  always_comb begin
    gnt_src = SRC_NONE;
    if (boost_q)        gnt_src = SRC_FIFO;
    else if (boost_i)   gnt_src = SRC_IO;
    else if (alu_valid) gnt_src = SRC_ALU;
    else if (qv)        gnt_src = SRC_FIFO;
    else if (io_valid)  gnt_src = SRC_IO;
  end

  assign alu_ready = (gnt_src == SRC_ALU);
  assign io_ready  = (gnt_src == SRC_IO);

  always_comb begin
    gnt_reg  = '0;
    gnt_data = '0;
    case (gnt_src)
      SRC_ALU: begin
        gnt_reg  = alu_reg;
        gnt_data = alu_data;
      end
      SRC_FIFO: begin
        gnt_reg  = q_reg[rd_idx];
        gnt_data = q_data[rd_idx];
      end
      SRC_IO: begin
        gnt_reg  = io_reg;
        gnt_data = io_data;
      end
      default: begin
        gnt_reg  = '0;
        gnt_data = '0;
      end
    endcase
  end

  // Walk the occupied slots from the head; register 0 never stalls decode.
  always_comb begin
    pend_c = '0;
    for (int k = 0; k < Q_DEPTH; k++) begin
      if (PTR_W'(k) < q_count) begin
        pend_c[q_reg[rd_idx + IDX_W'(k)]] = 1'b1;
      end
    end
    pend_c[0] = 1'b0;
  end

  assign pend_mask = pend_c;

  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_idx]  <= mem_reg;
      q_data[wr_idx] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sq       <= '0;
      si       <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (qv && (gnt_src != SRC_FIFO)) begin
        if (sq != SC_MAX) sq <= sq + SC_W'(1);
      end else begin
        sq <= '0;
      end

      if (io_valid && (gnt_src != SRC_IO)) begin
        if (si != SC_MAX) si <= si + SC_W'(1);
      end else begin
        si <= '0;
      end

      // Writes to register 0 are granted and consumed but never reach the file.
      if ((gnt_src != SRC_NONE) && (gnt_reg != '0)) begin
        rf_we    <= 1'b1;
        rf_waddr <= gnt_reg;
        rf_wdata <= gnt_data;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

endmodule
